// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite read initiator: FSM state encoding,
// RRESP codes and the default ARPROT value.
package axil_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } axil_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ARPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_watchdog.sv
// Transaction watchdog for the AXI4-Lite read initiator, instantiated only
// when AXIL_MRD_TIMEOUT_EN is defined. A 16-bit saturating counter runs
// while a transaction waits on the bus; reaching LIMIT-1 sets a sticky flag
// that only reset clears. The flag is advisory: the FSM keeps waiting.
module axil_watchdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  output logic timeout_err
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] count;

  // Wait counter: restarts on each new transaction, saturates at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (active && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

  // Sticky error flag, set once the counter has reached the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (count == LAST) begin
      timeout_err <= 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_master_read.sv
// AXI4-Lite read-channel initiator with one outstanding transaction.
// A user request is turned into an AR handshake followed by an R handshake;
// the returned data and response are held for the user until accepted.
// Optional watchdog: define AXIL_MRD_TIMEOUT_EN to instantiate axil_watchdog;
// otherwise timeout_err is tied low.
module axi_lite_master_read
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [2:0]  ARPROT_VAL     = ARPROT_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  M_AXIL_ACLK,
  input  logic                  M_AXIL_ARESET,
  output logic                  M_AXIL_ARVALID,
  input  logic                  M_AXIL_ARREADY,
  output logic [ADDR_WIDTH-1:0] M_AXIL_ARADDR,
  output logic [2:0]            M_AXIL_ARPROT,
  input  logic                  M_AXIL_RVALID,
  output logic                  M_AXIL_RREADY,
  input  logic [DATA_WIDTH-1:0] M_AXIL_RDATA,
  input  logic [1:0]            M_AXIL_RRESP,
  input  logic                  user_req_valid,
  output logic                  user_req_ready,
  input  logic [ADDR_WIDTH-1:0] user_req_addr,
  output logic                  user_rsp_valid,
  input  logic                  user_rsp_ready,
  output logic [DATA_WIDTH-1:0] user_rsp_data,
  output logic [1:0]            user_rsp_resp,
  output logic                  busy,
  output logic                  timeout_err
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  axil_state_e state;
  axil_state_e state_next;

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge M_AXIL_ACLK or posedge M_AXIL_ARESET) begin
    if (M_AXIL_ARESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode from the current state and the handshakes it waits on.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (user_req_valid)                   state_next = ST_ADDR;
      ST_ADDR: if (M_AXIL_ARVALID && M_AXIL_ARREADY) state_next = ST_DATA;
      ST_DATA: if (M_AXIL_RVALID && M_AXIL_RREADY)   state_next = ST_RESP;
      ST_RESP: if (user_rsp_ready)                   state_next = ST_IDLE;
      default:                                       state_next = ST_IDLE;
    endcase
  end

  // Registered bus and user outputs, updated on the handshake that ends each phase.
  // NOTE: the captured address and data registers are reset too, so the
  // outputs show zeros rather than stale values after a mid-transaction reset.
  always_ff @(posedge M_AXIL_ACLK or posedge M_AXIL_ARESET) begin
    if (M_AXIL_ARESET) begin
      M_AXIL_ARVALID <= 1'b0;
      M_AXIL_ARADDR  <= '0;
      M_AXIL_RREADY  <= 1'b0;
      user_rsp_valid <= 1'b0;
      user_rsp_data  <= '0;
      user_rsp_resp  <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (user_req_valid) begin
            M_AXIL_ARADDR  <= user_req_addr;
            M_AXIL_ARVALID <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (M_AXIL_ARVALID && M_AXIL_ARREADY) begin
            M_AXIL_ARVALID <= 1'b0;
            M_AXIL_RREADY  <= 1'b1;
          end
        end
        ST_DATA: begin
          if (M_AXIL_RVALID && M_AXIL_RREADY) begin
            M_AXIL_RREADY  <= 1'b0;
            user_rsp_valid <= 1'b1;
            user_rsp_data  <= M_AXIL_RDATA;
            user_rsp_resp  <= M_AXIL_RRESP;
          end
        end
        ST_RESP: begin
          if (user_rsp_ready) begin
            user_rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign user_req_ready = (state == ST_IDLE);
  assign busy           = (state != ST_IDLE);
  assign M_AXIL_ARPROT  = ARPROT_VAL;

`ifdef AXIL_MRD_TIMEOUT_EN
  logic wd_clear;
  logic wd_active;

  assign wd_clear  = (state == ST_IDLE) && user_req_valid;
  assign wd_active = (state == ST_ADDR) || (state == ST_DATA);

  axil_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk        (M_AXIL_ACLK),
    .rst        (M_AXIL_ARESET),
    .clear      (wd_clear),
    .active     (wd_active),
    .timeout_err(timeout_err)
  );
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_master_read.sv
// Self-checking bench for axi_lite_master_read: a vector table of directed
// reads, randomized reads against a behavioural expectation, and hand-written
// reset and (with AXIL_MRD_TIMEOUT_EN) watchdog sequences.
module tb_axi_lite_master_read;
  import axil_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          req_valid, req_ready, rsp_valid, rsp_ready, busy, timeout_err;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_resp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_lite_master_read #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .ARPROT_VAL    (3'b000),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .M_AXIL_ACLK   (clk),
    .M_AXIL_ARESET (rst),
    .M_AXIL_ARVALID(arvalid),
    .M_AXIL_ARREADY(arready),
    .M_AXIL_ARADDR (araddr),
    .M_AXIL_ARPROT (arprot),
    .M_AXIL_RVALID (rvalid),
    .M_AXIL_RREADY (rready),
    .M_AXIL_RDATA  (rdata),
    .M_AXIL_RRESP  (rresp),
    .user_req_valid(req_valid),
    .user_req_ready(req_ready),
    .user_req_addr (req_addr),
    .user_rsp_valid(rsp_valid),
    .user_rsp_ready(rsp_ready),
    .user_rsp_data (rsp_data),
    .user_rsp_resp (rsp_resp),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          ar_wait;
    int          r_wait;
    int          u_wait;
    bit          poke;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete read, cycle by cycle. The slave answers after the given
  // wait counts; with poke set, stray user requests are driven while busy.
  task automatic run_read(input string tag, input logic [31:0] addr,
                          input logic [31:0] sl_data, input logic [1:0] sl_resp,
                          input int ar_wait, input int r_wait, input int u_wait,
                          input bit poke, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    check({tag, " idle req_ready"}, req_ready, 1);
    check({tag, " idle busy"}, busy, 0);
    req_valid = 1'b1;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i <= ar_wait; i++) begin
      check({tag, " addr arvalid"}, arvalid, 1);
      check({tag, " addr araddr"}, araddr, addr);
      check({tag, " addr rready"}, rready, 0);
      if (poke) begin
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
      end
      arready = (i == ar_wait);
      tick();
    end
    arready = 1'b0;
    for (int i = 0; i <= r_wait; i++) begin
      check({tag, " data arvalid"}, arvalid, 0);
      check({tag, " data rready"}, rready, 1);
      check({tag, " data rsp_valid"}, rsp_valid, 0);
      if (poke) begin
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
      end
      if (i == r_wait) begin
        rvalid = 1'b1;
        rdata  = sl_data;
        rresp  = sl_resp;
      end else begin
        rvalid = 1'b0;
        rdata  = $urandom;
        rresp  = 2'($urandom);
      end
      tick();
    end
    rvalid = 1'b0;
    rdata  = $urandom;
    for (int i = 0; i <= u_wait; i++) begin
      check({tag, " resp rsp_valid"}, rsp_valid, 1);
      check({tag, " resp data"}, rsp_data, exp_data);
      check({tag, " resp code"}, rsp_resp, exp_resp);
      check({tag, " resp req_ready"}, req_ready, 0);
      check({tag, " resp rready"}, rready, 0);
      if (poke) begin
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
      end
      rsp_ready = (i == u_wait);
      tick();
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check({tag, " done rsp_valid"}, rsp_valid, 0);
    check({tag, " done busy"}, busy, 0);
    check({tag, " done arvalid"}, arvalid, 0);
`ifndef AXIL_MRD_TIMEOUT_EN
    check({tag, " timeout_err"}, timeout_err, 0);
`endif
  endtask

  // Start a read, stop it in the given phase (0 ADDR, 1 DATA, 2 RESP) and
  // assert reset between clock edges.
  task automatic reset_in(input string tag, input int phase);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0ABC;
    tick();
    req_valid = 1'b0;
    if (phase >= 1) begin
      arready = 1'b1;
      tick();
      arready = 1'b0;
    end
    if (phase >= 2) begin
      rvalid = 1'b1;
      rdata  = 32'hCAFE_F00D;
      rresp  = RESP_EXOKAY;
      tick();
      rvalid = 1'b0;
    end
    check({tag, " busy before reset"}, busy, 1);
    #2 rst = 1'b1;
    #1;
    check({tag, " async arvalid"}, arvalid, 0);
    check({tag, " async rready"}, rready, 0);
    check({tag, " async rsp_valid"}, rsp_valid, 0);
    check({tag, " async rsp_data"}, rsp_data, 0);
    check({tag, " async araddr"}, araddr, 0);
    check({tag, " async busy"}, busy, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check({tag, " post busy"}, busy, 0);
    check({tag, " post req_ready"}, req_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst       = 1'b1;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rdata     = '0;
    rresp     = RESP_OKAY;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;

    vecs[0] = '{32'h0000_0040, 32'hDEAD_BEEF, RESP_OKAY,   0, 0, 0, 1'b0, 32'hDEAD_BEEF, RESP_OKAY};
    vecs[1] = '{32'h0000_1000, 32'hA5A5_0F0F, RESP_OKAY,   5, 0, 0, 1'b1, 32'hA5A5_0F0F, RESP_OKAY};
    vecs[2] = '{32'h0000_2000, 32'h1234_5678, RESP_OKAY,   0, 0, 4, 1'b1, 32'h1234_5678, RESP_OKAY};
    vecs[3] = '{32'h0000_0008, 32'h0000_0000, RESP_SLVERR, 0, 0, 0, 1'b0, 32'h0000_0000, RESP_SLVERR};
    vecs[4] = '{32'h0000_0004, 32'h0BAD_CAFE, RESP_OKAY,   0, 0, 0, 1'b0, 32'h0BAD_CAFE, RESP_OKAY};
    vecs[5] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, RESP_DECERR, 1, 3, 1, 1'b1, 32'hFFFF_FFFF, RESP_DECERR};
    vecs[6] = '{32'h8000_0010, 32'h5555_AAAA, RESP_EXOKAY, 2, 1, 2, 1'b0, 32'h5555_AAAA, RESP_EXOKAY};

    @(negedge clk);
    @(negedge clk);
    check("reset arvalid", arvalid, 0);
    check("reset rready", rready, 0);
    check("reset araddr", araddr, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_data", rsp_data, 0);
    check("reset rsp_resp", rsp_resp, 0);
    check("reset busy", busy, 0);
    check("reset req_ready", req_ready, 1);
    check("reset timeout_err", timeout_err, 0);
    check("arprot", arprot, 3'b000);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      run_read($sformatf("vec%0d", v), vecs[v].addr, vecs[v].rdata, vecs[v].rresp,
               vecs[v].ar_wait, vecs[v].r_wait, vecs[v].u_wait, vecs[v].poke,
               vecs[v].exp_data, vecs[v].exp_resp);
    end

    // Randomized reads: the initiator must pass RDATA/RRESP through unchanged
    // and present the requested address whatever the handshake timing.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a, d;
      logic [1:0]  r;
      a = $urandom;
      d = $urandom;
      r = 2'($urandom);
      run_read($sformatf("rnd%0d", n), a, d, r, $urandom_range(0, 2),
               $urandom_range(0, 2), $urandom_range(0, 3), 1'b1, d, r);
    end

    reset_in("rst_addr", 0);
    reset_in("rst_data", 1);
    reset_in("rst_resp", 2);
    run_read("after_reset", 32'h0000_0100, 32'h0102_0304, RESP_OKAY, 0, 0, 0, 1'b0,
             32'h0102_0304, RESP_OKAY);

`ifdef AXIL_MRD_TIMEOUT_EN
    check("wd clear after short read", timeout_err, 0);
    run_read("wd_long", 32'h0000_0200, 32'h7777_0001, RESP_OKAY, 0, 20, 0, 1'b0,
             32'h7777_0001, RESP_OKAY);
    check("wd set after long wait", timeout_err, 1);
    run_read("wd_sticky", 32'h0000_0204, 32'h7777_0002, RESP_OKAY, 0, 0, 0, 1'b0,
             32'h7777_0002, RESP_OKAY);
    check("wd sticky", timeout_err, 1);
`else
    check("timeout_err tied low", timeout_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
